// File: rtl/pkt_commit_fifo.sv
// Packet commit FIFO: words are written speculatively and only become readable once
// their packet commits; aborted or oversize packets are rolled back and never emitted.
module pkt_commit_fifo #(
   parameter int width = 64,
   parameter int depth = 16,
   parameter int asz   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p_srdy,
   output logic             p_drdy,
   input  logic [width-1:0] p_data,
   input  logic             p_commit,
   input  logic             p_abort,
   output logic             f_srdy,
   input  logic             f_drdy,
   output logic [width-1:0] f_data,
   output logic             f_eop,
   output logic             ovf_err
);

   localparam int PW = asz + 1;

   typedef enum logic {NORMAL, DROP} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     com_ptr_q, com_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              ovf_err_q, ovf_err_d;
   logic [width:0]    mem_q [depth];

   logic [PW-1:0]     used;
   logic              full;
   logic              empty_out;
   logic              ovf_cond;
   logic              pkt_end;
   logic              wr_en;
   logic [width:0]    head;

   assign used      = wr_ptr_q - rd_ptr_q;
   assign full      = (used == PW'(depth));
   assign empty_out = (rd_ptr_q == com_ptr_q);
   assign ovf_cond  = (state_q == NORMAL) && full && (com_ptr_q == rd_ptr_q);
   assign pkt_end   = p_abort | (p_srdy & p_commit);

   assign head    = mem_q[rd_ptr_q[asz-1:0]];
   assign f_data  = head[width-1:0];
   assign f_eop   = head[width];
   assign f_srdy  = ~empty_out;
   assign ovf_err = ovf_err_q;

   // The overflow cycle already behaves like DROP (p_drdy high, word discarded), so a
   // commit or abort arriving in that same cycle ends the dropped packet immediately.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      com_ptr_d = com_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ovf_err_d = 1'b0;
      wr_en     = 1'b0;
      p_drdy    = 1'b1;

      case (state_q)
         NORMAL: begin
            if (ovf_cond) begin
               wr_ptr_d  = com_ptr_q;
               ovf_err_d = 1'b1;
               if (!pkt_end)
                  state_d = DROP;
            end else begin
               p_drdy = ~full;
               if (p_abort) begin
                  wr_ptr_d = com_ptr_q;
               end else if (p_srdy && !full) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  if (p_commit)
                     com_ptr_d = wr_ptr_q + 1'b1;
               end
            end
         end
         DROP: begin
            if (pkt_end)
               state_d = NORMAL;
         end
      endcase

      if (f_srdy && f_drdy)
         rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= NORMAL;
         wr_ptr_q  <= '0;
         com_ptr_q <= '0;
         rd_ptr_q  <= '0;
         ovf_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         com_ptr_q <= com_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ovf_err_q <= ovf_err_d;
      end
   end

   // Storage is data only; pointer reset makes stale contents unreachable.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q[asz-1:0]] <= {p_commit, p_data};
   end

endmodule

// File: tb/tb_pkt_commit_fifo.sv
// Directed bench for pkt_commit_fifo: a scoreboard queue holds the {eop,data} words
// expected at the output, and a negedge monitor compares every accepted output word.
module tb_pkt_commit_fifo;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         reset;
   logic         p_srdy, p_drdy, p_commit, p_abort;
   logic [W-1:0] p_data;
   logic         f_srdy, f_drdy, f_eop, ovf_err;
   logic [W-1:0] f_data;

   int checks = 0;
   int errors = 0;

   logic [W:0]   sb [$];
   logic [W:0]   mexp;

   logic watch = 1'b0;
   int   ovf_cnt = 0;
   int   drdy_low = 0;
   int   fs_hi = 0;

   always #5 clk = ~clk;

   pkt_commit_fifo #(.width(W), .depth(16), .asz(4)) dut (
      .clk      (clk),
      .reset    (reset),
      .p_srdy   (p_srdy),
      .p_drdy   (p_drdy),
      .p_data   (p_data),
      .p_commit (p_commit),
      .p_abort  (p_abort),
      .f_srdy   (f_srdy),
      .f_drdy   (f_drdy),
      .f_data   (f_data),
      .f_eop    (f_eop),
      .ovf_err  (ovf_err)
   );

   task automatic check_word(input string name, input logic [W:0] act, input logic [W:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] d, input logic c);
      int   n;
      logic ok;
      n = 0;
      ok = 1'b0;
      p_srdy   = 1'b1;
      p_data   = d;
      p_commit = c;
      do begin
         @(negedge clk);
         ok = p_drdy;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 200);
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL send_timeout actual=p_drdy_low required=accept data=%h", d);
      end
      p_srdy   = 1'b0;
      p_commit = 1'b0;
   endtask

   // Output monitor: every accepted output word must match the scoreboard head.
   always @(negedge clk) begin
      if (reset === 1'b0 && f_srdy === 1'b1 && f_drdy === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out actual=%h required=none", {f_eop, f_data});
         end else begin
            mexp = sb.pop_front();
            check_word("out_word", {f_eop, f_data}, mexp);
         end
      end
   end

   always @(negedge clk) begin
      if (watch) begin
         if (ovf_err === 1'b1) ovf_cnt++;
         if (p_drdy !== 1'b1) drdy_low++;
         if (f_srdy !== 1'b0) fs_hi++;
      end
   end

   initial begin
      logic [W-1:0] v;
      int           n;
      reset    = 1'b1;
      p_srdy   = 1'b0;
      p_commit = 1'b0;
      p_abort  = 1'b0;
      p_data   = '0;
      f_drdy   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_bit("rst_f_srdy", f_srdy, 1'b0);
      check_bit("rst_p_drdy", p_drdy, 1'b1);
      check_bit("rst_ovf_err", ovf_err, 1'b0);

      // Single 3-word packet
      f_drdy = 1'b1;
      sb.push_back({1'b0, 64'hA0A0_0000_0000_0000});
      sb.push_back({1'b0, 64'hA0A0_0000_0000_0001});
      sb.push_back({1'b1, 64'hA0A0_0000_0000_0002});
      send_word(64'hA0A0_0000_0000_0000, 1'b0);
      send_word(64'hA0A0_0000_0000_0001, 1'b0);
      check_bit("t1_uncommitted_hidden", f_srdy, 1'b0);
      send_word(64'hA0A0_0000_0000_0002, 1'b1);
      check_bit("t1_visible_after_commit", f_srdy, 1'b1);
      tick(5);
      check_bit("t1_idle", f_srdy, 1'b0);

      // Abort rolls back B0,B1; only C0 appears
      send_word(64'hB0B0_0000_0000_0000, 1'b0);
      send_word(64'hB0B0_0000_0000_0001, 1'b0);
      check_bit("t2_b_hidden", f_srdy, 1'b0);
      p_abort = 1'b1;
      tick(1);
      p_abort = 1'b0;
      sb.push_back({1'b1, 64'hC0C0_0000_0000_0000});
      send_word(64'hC0C0_0000_0000_0000, 1'b1);
      tick(4);
      check_bit("t2_drained", f_srdy, 1'b0);

      // Backpressure: 16 committed words fill the buffer
      f_drdy = 1'b0;
      for (int p = 0; p < 4; p++) begin
         for (int w = 0; w < 4; w++) begin
            v = 64'hD000 + 64'(p * 4 + w);
            sb.push_back({(w == 3), v});
            send_word(v, (w == 3));
         end
      end
      check_bit("t3_full_p_drdy", p_drdy, 1'b0);
      check_bit("t3_full_f_srdy", f_srdy, 1'b1);
      f_drdy = 1'b1;
      tick(1);
      f_drdy = 1'b0;
      check_bit("t3_drdy_after_read", p_drdy, 1'b1);
      sb.push_back({1'b1, 64'hD0FF});
      send_word(64'hD0FF, 1'b1);
      check_bit("t3_refull_p_drdy", p_drdy, 1'b0);
      f_drdy = 1'b1;
      tick(25);
      check_int("t3_drained", sb.size(), 0);

      // Oversize 17-word packet is dropped
      watch = 1'b1;
      for (int i = 0; i < 17; i++)
         send_word(64'hE000 + 64'(i), (i == 16));
      tick(2);
      watch = 1'b0;
      check_int("t4_ovf_pulses", ovf_cnt, 1);
      check_int("t4_p_drdy_low_cycles", drdy_low, 0);
      check_int("t4_f_srdy_high_cycles", fs_hi, 0);
      sb.push_back({1'b0, 64'hF0F0_0000_0000_0000});
      sb.push_back({1'b1, 64'hF0F0_0000_0000_0001});
      send_word(64'hF0F0_0000_0000_0000, 1'b0);
      send_word(64'hF0F0_0000_0000_0001, 1'b1);
      tick(5);
      check_int("t4_f_delivered", sb.size(), 0);

      // Collision: srdy+commit+abort together with a concurrent read of G0
      f_drdy = 1'b0;
      sb.push_back({1'b1, 64'h6060_0000_0000_0000});
      send_word(64'h6060_0000_0000_0000, 1'b1);
      send_word(64'h7070_0000_0000_0000, 1'b0);
      p_srdy   = 1'b1;
      p_data   = 64'h8080_0000_0000_0000;
      p_commit = 1'b1;
      p_abort  = 1'b1;
      f_drdy   = 1'b1;
      tick(1);
      p_srdy   = 1'b0;
      p_commit = 1'b0;
      p_abort  = 1'b0;
      f_drdy   = 1'b0;
      check_int("t5_g0_read", sb.size(), 0);
      check_bit("t5_no_commit", f_srdy, 1'b0);
      f_drdy = 1'b1;
      sb.push_back({1'b1, 64'h9090_0000_0000_0000});
      send_word(64'h9090_0000_0000_0000, 1'b1);
      tick(4);
      check_bit("t5_idle", f_srdy, 1'b0);

      // Reset mid-packet discards committed-unread and uncommitted words
      f_drdy = 1'b0;
      send_word(64'h1111_0000_0000_0000, 1'b0);
      send_word(64'h1111_0000_0000_0001, 1'b1);
      for (int i = 0; i < 5; i++)
         send_word(64'h2222_0000_0000_0000 + 64'(i), 1'b0);
      check_bit("t6_pre_f_srdy", f_srdy, 1'b1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_bit("t6_rst_f_srdy", f_srdy, 1'b0);
      check_bit("t6_rst_p_drdy", p_drdy, 1'b1);
      f_drdy = 1'b1;
      sb.push_back({1'b0, 64'h3333_0000_0000_0000});
      sb.push_back({1'b1, 64'h3333_0000_0000_0001});
      send_word(64'h3333_0000_0000_0000, 1'b0);
      send_word(64'h3333_0000_0000_0001, 1'b1);
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         tick(1);
         n++;
      end
      tick(3);
      check_int("final_sb_empty", sb.size(), 0);
      check_bit("final_idle", f_srdy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pkt_commit_fifo.md
Name: pkt_commit_fifo

Overview:
- Packet buffer directly downstream of the byte-to-word concentrator.
- Accepts packed words with commit/abort qualifiers and writes them speculatively.
- Releases words to the consumer only once the packet that contains them is committed. An aborted packet is rolled back and never appears at the output.
- Output is a srdy/drdy word stream with an end-of-packet flag, for the egress/transmit stage.

Parameters:
- width, 64, data word width (matches packed word size `PFW_SZ`)
- depth, 16, number of entries; must be a power of 2
- asz, 4, log2(depth)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- p_srdy  input  1  word valid from upstream
- p_drdy  output  1  buffer can accept a word
- p_data  input  width  packed data word
- p_commit  input  1  qualifies p_srdy: this word ends a good packet
- p_abort  input  1  single-cycle pulse: discard the current uncommitted packet
- f_srdy  output  1  committed word available
- f_drdy  input  1  consumer accepts word
- f_data  output  width  head word
- f_eop  output  1  head word is last word of its packet
- ovf_err  output  1  one-cycle pulse: packet dropped for exceeding depth

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Storage:
  - Flop array of depth x (width+1); the extra bit holds eop.
  - Three pointers, each asz+1 bits with wrap bit: wr_ptr (speculative), com_ptr (committed), rd_ptr.
  - Increments wrap modulo 2^(asz+1).
- Reset: wr_ptr = com_ptr = rd_ptr = 0, state = NORMAL, ovf_err = 0.
  - Outputs after reset: f_srdy = 0, p_drdy = 1.
  - Reset mid-packet discards all stored and uncommitted data.
- Derived values:
  - used = wr_ptr - com_ptr + (com_ptr - rd_ptr) = wr_ptr - rd_ptr.
  - full = (used == depth).
  - empty_out = (rd_ptr == com_ptr).
- Write side, state NORMAL:
  - p_drdy = ~full.
  - On p_srdy & p_drdy: write {p_commit, p_data} at wr_ptr; wr_ptr += 1.
  - If p_commit is also set, com_ptr <= wr_ptr + 1 on the same edge.
- Abort:
  - On p_abort: wr_ptr <= com_ptr, regardless of p_srdy.
  - Abort has priority: a simultaneous p_srdy word is dropped and a simultaneous p_commit is ignored.
  - Abort with no uncommitted words is a no-op.
- Read side:
  - f_srdy = ~empty_out.
  - f_data and f_eop are read combinationally from entry rd_ptr.
  - On f_srdy & f_drdy: rd_ptr += 1.
  - Latency: a word committed at edge N is visible with f_srdy = 1 in the cycle following edge N. Uncommitted words are never visible.
- Simultaneous read and write in the same cycle are independent.
  - p_drdy is computed from pre-edge pointers; there is no read-to-write bypass while full.
- Overflow state machine, states NORMAL and DROP:
  - NORMAL -> DROP when full & (com_ptr == rd_ptr), i.e. the entire buffer holds one uncommitted packet.
  - On that transition: wr_ptr <= com_ptr and ovf_err pulses high for 1 cycle.
  - In DROP: p_drdy = 1 and all incoming words are discarded; no pointer moves on the write side.
  - DROP -> NORMAL on an accepted word with p_commit, or on p_abort. That terminating word is also discarded.
  - The read side operates normally in DROP.
- Full with committed data present: p_drdy stays low until the consumer drains entries (backpressure, no drop).
- Words between packets need no SOP marker; a packet boundary is defined solely by the preceding eop.

Test Plan:
- Single packet: 3 words A0..A2 with commit on A2, f_drdy = 1 -> f_srdy rises the cycle after the A2 edge; outputs A0, A1, A2 with f_eop = 0, 0, 1; f_srdy then returns to 0.
- Abort: 2 words B0, B1, then p_abort pulse, then a 1-word committed packet C0 -> output is only C0 with f_eop = 1; B0 and B1 never appear.
- Backpressure: f_drdy = 0, write committed packets totalling 16 words -> p_drdy = 0 after the 16th word; one f_drdy pulse -> p_drdy = 1 the next cycle; data order preserved.
- Oversize: empty buffer, 17-word packet without commit until word 17 -> ovf_err pulses once when used reaches 16; p_drdy stays 1; f_srdy stays 0; the following 2-word committed packet is delivered intact.
- Collisions: p_srdy + p_commit + p_abort in the same cycle -> word dropped and com_ptr unchanged; a concurrent read of earlier committed data completes normally.
- Reset mid-packet: 5 uncommitted words plus 2 committed words unread, then reset for 1 cycle -> f_srdy = 0, p_drdy = 1; a subsequent packet passes correctly.
